fifo_burst_reader: RTL and testbench

Drains a fixed-length burst of words from the read port of the team's SDPRAM-based FIFO and presents them as a valid/ready stream with a last-word marker.
- Absorbs the FIFO's 1-cycle read latency and its non-holding output with a small skid buffer.
- Consumers such as the Kyber512 polynomial and NTT units can apply arbitrary backpressure.
- Sits between the FIFO read port and any downstream stream consumer.

---
 rtl/fifo_burst_pkg.sv | 14 +
 rtl/fifo_burst_reader_if.sv | 22 ++
 rtl/fifo_burst_skid.sv | 41 ++++
 rtl/fifo_burst_reader.sv | 92 +++++++++
 tb/tb_fifo_burst_reader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding and skid-buffer sizing.
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 3;
    // Reads in flight plus buffered words may never exceed the skid capacity.
    localparam int CREDIT_LIMIT = SKID_DEPTH;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port and downstream valid/ready stream seen by the burst reader.
interface fifo_burst_reader_if #(parameter int DWIDTH = 32);

    logic              FIFO_RD_EN;
    logic [DWIDTH-1:0] FIFO_DOUT;
    logic              FIFO_EMPTY;
    logic              M_VALID;
    logic              M_READY;
    logic [DWIDTH-1:0] M_DATA;
    logic              M_LAST;

    modport master (
        output FIFO_RD_EN, M_VALID, M_DATA, M_LAST,
        input  FIFO_DOUT, FIFO_EMPTY, M_READY
    );

    modport slave (
        input  FIFO_RD_EN, M_VALID, M_DATA, M_LAST,
        output FIFO_DOUT, FIFO_EMPTY, M_READY
    );

endinterface

// File: rtl/fifo_burst_skid.sv
// Three-entry in-order queue; entry 0 is always the head, so the head keeps
// its last value once the queue drains.
module fifo_burst_skid
    import fifo_burst_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DWIDTH-1:0] head
);

    logic [DWIDTH-1:0] entry [SKID_DEPTH];
    logic              pop_ok;
    logic [1:0]        wr_idx;

    assign pop_ok = pop && (occ != 2'd0);
    assign wr_idx = occ - {1'b0, pop_ok};
    assign head   = entry[0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            occ <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) entry[i] <= '0;
        end else begin
            // Shift only occupied entries so a drained head is not overwritten by stale data.
            if (pop_ok) begin
                for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                    if (i + 1 < int'(occ)) entry[i] <= entry[i+1];
                end
            end
            if (push && int'(wr_idx) < SKID_DEPTH) entry[wr_idx] <= push_data;
            occ <= occ + {1'b0, push} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a fixed-length burst from the FIFO read port into a valid/ready stream,
// absorbing the one-cycle read latency with a credit-limited skid buffer.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int LWIDTH = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [LWIDTH-1:0] LEN,
    output logic              BUSY,
    output logic              DONE,
    fifo_burst_reader_if.master bus
);

    localparam logic [LWIDTH-1:0] ONE = LWIDTH'(1);

    state_t            state_q, state_d;
    logic [LWIDTH-1:0] len_q, issue_cnt, out_cnt, last_idx;
    logic              pend, rd_en, hs, accept;
    logic [1:0]        occ;
    logic [DWIDTH-1:0] head;

    assign last_idx = len_q - ONE;
    assign accept   = (state_q == IDLE) && START;
    assign hs       = bus.M_VALID && bus.M_READY;

    // Issue depends only on registered state and FIFO_EMPTY, never on M_READY.
    assign rd_en = (state_q == BURST) && !bus.FIFO_EMPTY && (issue_cnt < len_q) &&
                   (({1'b0, occ} + {2'b00, pend}) < 3'(CREDIT_LIMIT));

    assign bus.FIFO_RD_EN = rd_en;
    assign bus.M_VALID    = (occ != 2'd0);
    assign bus.M_DATA     = head;
    assign bus.M_LAST     = bus.M_VALID && (out_cnt == last_idx);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        case (state_q)
            IDLE:  if (START) state_d = (LEN != '0) ? BURST : FIN;
            BURST: begin
                BUSY = 1'b1;
                if (hs && out_cnt == last_idx) state_d = FIN;
            end
            FIN: begin
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_q     <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            pend      <= 1'b0;
        end else begin
            pend <= rd_en;
            if (accept) begin
                len_q     <= LEN;
                issue_cnt <= '0;
                out_cnt   <= '0;
            end else begin
                if (rd_en) issue_cnt <= issue_cnt + ONE;
                if (hs)    out_cnt   <= out_cnt + ONE;
            end
        end
    end

    // pend marks the cycle FIFO_DOUT is valid; credit accounting guarantees room.
    fifo_burst_skid #(.DWIDTH(DWIDTH)) u_skid (
        .CLK       (CLK),
        .RST       (RST),
        .push      (pend),
        .push_data (bus.FIFO_DOUT),
        .pop       (hs),
        .occ       (occ),
        .head      (head)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader with a behavioural non-holding FIFO model.
module tb_fifo_burst_reader;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [8:0]  LEN;
    logic        BUSY;
    logic        DONE;

    fifo_burst_reader_if #(.DWIDTH(32)) bus ();

    fifo_burst_reader #(.DWIDTH(32), .LWIDTH(9)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .LEN   (LEN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // FIFO model: one-cycle read latency, output garbage when not read.
    logic        wr_req = 1'b0;
    logic        flush  = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] fmem [0:1023];
    int          wp = 0;
    int          rp = 0;
    int          rd_total = 0;
    int          hs_total = 0;
    int          last_cnt = 0;
    int          done_cnt = 0;
    int          out_base = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    assign bus.FIFO_EMPTY = (wp == rp);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (flush) begin
            rp <= wp;
        end else if (bus.FIFO_RD_EN && wp != rp) begin
            bus.FIFO_DOUT <= fmem[rp];
            rp            <= rp + 1;
            rd_total      <= rd_total + 1;
        end
        if (!bus.FIFO_RD_EN) bus.FIFO_DOUT <= $urandom;
        if (wr_req) begin
            fmem[wp] <= wr_data;
            wp       <= wp + 1;
        end
    end

    // Monitor: sees the stream half a cycle before the edge that completes a handshake.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(bus.M_VALID), 64'(1));
                chk("stall_data", 64'(bus.M_DATA), 64'(prev_data));
            end
            if (bus.FIFO_RD_EN) begin
                chk("rd_while_empty", 64'(bus.FIFO_EMPTY), 64'(0));
                chk("rd_outside_burst", 64'(BUSY), 64'(1));
            end
            chk("outstanding_le_3", 64'((rd_total - hs_total - out_base) <= 3), 64'(1));
            if (bus.M_VALID && bus.M_READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected no word", bus.M_DATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 64'(bus.M_DATA), 64'(e.data));
                    chk("last", 64'(bus.M_LAST), 64'(e.last));
                end
                hs_total++;
                if (bus.M_LAST) last_cnt++;
            end
            prev_stall = bus.M_VALID && !bus.M_READY;
            prev_data  = bus.M_DATA;
            if (DONE) done_cnt++;
        end
    end

    task automatic wait_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_req  = 1'b1;
            wr_data = base + 32'(i);
            exp_q.push_back('{last: (i == n - 1), data: base + 32'(i)});
            wait_cycle;
        end
        wr_req = 1'b0;
    endtask

    task automatic start_burst(input logic [8:0] n);
        START = 1'b1;
        LEN   = n;
        wait_cycle;
        START = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (DONE) begin
                found = 1'b1;
                break;
            end
            wait_cycle;
        end
        chk(name, 64'(found), 64'(1));
        wait_cycle;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   rd0, hs0, last0;
        logic found;
        RST = 1'b1; START = 1'b0; LEN = '0; bus.M_READY = 1'b1;
        repeat (2) wait_cycle;
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_done", 64'(DONE), 64'(0));
        chk("rst_rd_en", 64'(bus.FIFO_RD_EN), 64'(0));
        chk("rst_valid", 64'(bus.M_VALID), 64'(0));
        chk("rst_data", 64'(bus.M_DATA), 64'(0));
        chk("rst_last", 64'(bus.M_LAST), 64'(0));
        RST = 1'b0;
        wait_cycle;

        // LEN=4, ready always high
        preload(32'hA0, 4);
        rd0 = rd_total;
        start_burst(9'd4);
        chk("t1_rd_c0", 64'(bus.FIFO_RD_EN), 64'(1));
        chk("t1_busy", 64'(BUSY), 64'(1));
        chk("t1_valid_c0", 64'(bus.M_VALID), 64'(0));
        wait_cycle;
        chk("t1_rd_c1", 64'(bus.FIFO_RD_EN), 64'(1));
        chk("t1_valid_c1", 64'(bus.M_VALID), 64'(0));
        wait_cycle;
        chk("t1_rd_c2", 64'(bus.FIFO_RD_EN), 64'(1));
        chk("t1_valid_c2", 64'(bus.M_VALID), 64'(1));
        chk("t1_data_c2", 64'(bus.M_DATA), 64'(32'hA0));
        wait_cycle;
        chk("t1_rd_c3", 64'(bus.FIFO_RD_EN), 64'(1));
        wait_cycle;
        chk("t1_rd_c4", 64'(bus.FIFO_RD_EN), 64'(0));
        wait_cycle;
        chk("t1_last_c5", 64'(bus.M_LAST), 64'(1));
        chk("t1_data_c5", 64'(bus.M_DATA), 64'(32'hA3));
        wait_cycle;
        chk("t1_done", 64'(DONE), 64'(1));
        chk("t1_busy_in_done", 64'(BUSY), 64'(0));
        wait_cycle;
        chk("t1_done_pulse", 64'(DONE), 64'(0));
        chk("t1_reads", 64'(rd_total - rd0), 64'(4));

        // LEN=6 with downstream stall
        preload(32'hB0, 6);
        rd0 = rd_total;
        start_burst(9'd6);
        wait_cycle;
        bus.M_READY = 1'b0;
        repeat (3) wait_cycle;
        chk("t2_stall_rd", 64'(bus.FIFO_RD_EN), 64'(0));
        chk("t2_stall_data", 64'(bus.M_DATA), 64'(32'hB0));
        wait_cycle;
        bus.M_READY = 1'b1;
        wait_done("t2_done", 40);
        chk("t2_reads", 64'(rd_total - rd0), 64'(6));

        // LEN=3 with FIFO empty at start
        rd0 = rd_total;
        for (int i = 0; i < 3; i++) exp_q.push_back('{last: (i == 2), data: 32'hC0 + 32'(i)});
        start_burst(9'd3);
        for (int c = 1, k = 0; c <= 12; c++) begin
            wr_req  = (c == 5 || c == 9 || c == 10);
            wr_data = 32'hC0 + 32'(k);
            if (wr_req) k++;
            if (c <= 5) chk("t3_no_rd_empty", 64'(bus.FIFO_RD_EN), 64'(0));
            wait_cycle;
        end
        wr_req = 1'b0;
        wait_done("t3_done", 30);
        chk("t3_reads", 64'(rd_total - rd0), 64'(3));

        // LEN=0, then START while busy
        rd0 = rd_total;
        start_burst(9'd0);
        chk("t4_done", 64'(DONE), 64'(1));
        chk("t4_busy", 64'(BUSY), 64'(0));
        chk("t4_valid", 64'(bus.M_VALID), 64'(0));
        wait_cycle;
        chk("t4_done_pulse", 64'(DONE), 64'(0));
        chk("t4_reads", 64'(rd_total - rd0), 64'(0));
        preload(32'hD0, 2);
        rd0 = rd_total;
        start_burst(9'd2);
        START = 1'b1;
        LEN   = 9'd5;
        wait_cycle;
        START = 1'b0;
        wait_done("t4b_done", 30);
        chk("t4b_reads", 64'(rd_total - rd0), 64'(2));

        // Async reset after two of five words
        preload(32'hE0, 5);
        hs0 = hs_total;
        start_burst(9'd5);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (hs_total - hs0 == 2) begin
                found = 1'b1;
                break;
            end
            wait_cycle;
        end
        chk("t5_two_words", 64'(found), 64'(1));
        RST = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(BUSY), 64'(0));
        chk("t5_rst_rd_en", 64'(bus.FIFO_RD_EN), 64'(0));
        chk("t5_rst_valid", 64'(bus.M_VALID), 64'(0));
        chk("t5_rst_data", 64'(bus.M_DATA), 64'(0));
        chk("t5_rst_last", 64'(bus.M_LAST), 64'(0));
        exp_q.delete();
        flush = 1'b1;
        wait_cycle;
        flush    = 1'b0;
        out_base = rd_total - hs_total;
        wait_cycle;
        RST = 1'b0;
        wait_cycle;
        preload(32'hF0, 2);
        rd0 = rd_total;
        start_burst(9'd2);
        wait_done("t5b_done", 30);
        chk("t5b_reads", 64'(rd_total - rd0), 64'(2));

        // Full polynomial burst with random backpressure
        preload(32'h1000, 256);
        rd0 = rd_total; hs0 = hs_total; last0 = last_cnt;
        start_burst(9'd256);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus.M_READY = 1'($urandom_range(0, 1));
            wait_cycle;
            if (DONE) begin
                found = 1'b1;
                break;
            end
        end
        bus.M_READY = 1'b1;
        chk("t6_done", 64'(found), 64'(1));
        wait_cycle;
        chk("t6_reads", 64'(rd_total - rd0), 64'(256));
        chk("t6_handshakes", 64'(hs_total - hs0), 64'(256));
        chk("t6_last_once", 64'(last_cnt - last0), 64'(1));

        repeat (3) wait_cycle;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        chk("done_pulses", 64'(done_cnt), 64'(7));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
